// File: rtl/node_reset_sequencer_if.sv
// Reset-sequencer bus bundle: per-node reset requests in, node resets and status out.
interface node_reset_sequencer_if #(
  parameter int N_NODES = 3
);
  logic [N_NODES-1:0] rst_sel;
  logic [N_NODES-1:0] node_rst;
  logic [N_NODES-1:0] node_ready;
  logic               seq_busy;
  logic [7:0]         rst_event_cnt;

  // Sequencer side.
  modport master (
    input  rst_sel,
    output node_rst,
    output node_ready,
    output seq_busy,
    output rst_event_cnt
  );

  // Node / switch side.
  modport slave (
    output rst_sel,
    input  node_rst,
    input  node_ready,
    input  seq_busy,
    input  rst_event_cnt
  );
endinterface

// File: rtl/node_reset_sequencer.sv
// Node reset sequencer: stretches the global reset, releases nodes one at a time in
// index order, and serves per-node local reset requests with a minimum pulse width.
module node_reset_sequencer #(
  parameter int N_NODES        = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  node_reset_sequencer_if.master seq_if
);
  localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (N_NODES > 1) ? $clog2(N_NODES) : 1;

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LOAD     = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_START    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_START = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(N_NODES - 1);

  function automatic logic [3:0] popcount(input logic [N_NODES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_NODES; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b00000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [N_NODES-1:0] sync_q [SYNC_STAGES];
  logic [N_NODES-1:0] req, req_prev_q, req_rise;
  logic [CNT_W-1:0]   hold_cnt_q [N_NODES];
  logic [CNT_W-1:0]   hold_cnt_d [N_NODES];
  logic [N_NODES-1:0] hold_zero_d;
  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [N_NODES-1:0] released_q, released_d;
  logic               stall, rel_go;
  logic [N_NODES-1:0] node_rst_q, node_rst_d, node_ready_q;
  logic               seq_busy_q, seq_busy_d;
  logic [7:0]         evt_cnt_q, evt_cnt_d;

  // Synchronise the asynchronous active-low switches; flops idle high (no request).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
    end else begin
      sync_q[0] <= seq_if.rst_sel;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req      = ~sync_q[SYNC_STAGES-1];
  assign req_rise = req & ~req_prev_q;

  // Local hold counters: reload while requested, then run down to zero and stop.
  always_comb begin
    for (int i = 0; i < N_NODES; i++) begin
      hold_cnt_d[i]  = req[i] ? HOLD_LOAD
                              : ((hold_cnt_q[i] != '0) ? hold_cnt_q[i] - CNT_W'(1) : '0);
      hold_zero_d[i] = (hold_cnt_d[i] == '0);
    end
  end

  // Release sequencer. The step counter always runs down; at zero the current node is
  // released unless its local hold is still active this edge, in which case the release
  // waits and lands on the edge the local hold expires. Leaving HOLD releases node 0 on
  // the same edge, so HOLD and RELEASE share the release path.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < N_NODES; i++)
      if (idx_q == IDX_W'(i)) stall = ~hold_zero_d[i];
    rel_go     = (state_q != S_RUN) && (step_cnt_q == '0) && !stall;
    state_d    = state_q;
    idx_d      = idx_q;
    released_d = released_q;
    step_cnt_d = (step_cnt_q != '0) ? step_cnt_q - CNT_W'(1) : step_cnt_q;
    if (rel_go) begin
      for (int i = 0; i < N_NODES; i++)
        if (idx_q == IDX_W'(i)) released_d[i] = 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = S_RUN;
      end else begin
        state_d    = S_RELEASE;
        idx_d      = idx_q + IDX_W'(1);
        step_cnt_d = STAGGER_START;
      end
    end
    node_rst_d = ~(released_d & hold_zero_d);
    seq_busy_d = (state_d != S_RUN);
    evt_cnt_d  = sat_add8(evt_cnt_q, popcount(req_rise));
  end

  // State, counters and registered outputs; global reset restarts everything from HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HOLD;
      idx_q        <= '0;
      step_cnt_q   <= HOLD_START;
      released_q   <= '0;
      req_prev_q   <= '0;
      for (int i = 0; i < N_NODES; i++) hold_cnt_q[i] <= '0;
      node_rst_q   <= '1;
      node_ready_q <= '0;
      seq_busy_q   <= 1'b1;
      evt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      step_cnt_q   <= step_cnt_d;
      released_q   <= released_d;
      req_prev_q   <= req;
      for (int i = 0; i < N_NODES; i++) hold_cnt_q[i] <= hold_cnt_d[i];
      node_rst_q   <= node_rst_d;
      node_ready_q <= ~node_rst_d;
      seq_busy_q   <= seq_busy_d;
      evt_cnt_q    <= evt_cnt_d;
    end
  end

  assign seq_if.node_rst      = node_rst_q;
  assign seq_if.node_ready    = node_ready_q;
  assign seq_if.seq_busy      = seq_busy_q;
  assign seq_if.rst_event_cnt = evt_cnt_q;
endmodule
